// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit (shl, shr, sar, rol) shifting up to STEP bits per cycle with valid/ready on both sides.
// Optional shl overflow tracking is built only when SHIFT_UNIT_OVERFLOW_EN is defined; otherwise overflow is tied to 0.
module shift_unit #(
    parameter int WIDTH     = 12,
    parameter int AMT_WIDTH = 12,
    parameter int STEP      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [AMT_WIDTH-1:0] in_amount,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 overflow
);

    localparam int REM_W = $clog2(WIDTH + 1);
    localparam int EXT_W = ((AMT_WIDTH > REM_W) ? AMT_WIDTH : REM_W) + 1;

    localparam logic [1:0] MODE_SHL = 2'd0;
    localparam logic [1:0] MODE_SHR = 2'd1;
    localparam logic [1:0] MODE_SAR = 2'd2;
    localparam logic [1:0] MODE_ROL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     data_r;
    logic [1:0]           mode_r;
    logic [REM_W-1:0]     rem_r;
    logic [REM_W-1:0]     k;
    logic                 accept;

    // Shifts saturate at WIDTH; rotates wrap modulo WIDTH.
    function automatic logic [REM_W-1:0] eff_amount(input logic [1:0] mode,
                                                    input logic [AMT_WIDTH-1:0] amt);
        logic [EXT_W-1:0] a;
        logic [EXT_W-1:0] w;
        a = EXT_W'(amt);
        w = EXT_W'(WIDTH);
        if (mode == MODE_ROL) begin
            return REM_W'(a % w);
        end else if (a > w) begin
            return REM_W'(w);
        end else begin
            return REM_W'(a);
        end
    endfunction

    function automatic logic [REM_W-1:0] step_of(input logic [REM_W-1:0] rem);
        logic [REM_W-1:0] s;
        s = REM_W'(STEP);
        return (rem < s) ? rem : s;
    endfunction

    // One partial shift of k positions; k never exceeds WIDTH, and a shift by WIDTH yields 0.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] data,
                                                    input logic [1:0]       mode,
                                                    input logic [REM_W-1:0] amt);
        logic signed [WIDTH-1:0] sdata;
        logic [REM_W-1:0]        back;
        sdata = signed'(data);
        back  = REM_W'(WIDTH) - amt;
        case (mode)
            MODE_SHL: return data << amt;
            MODE_SHR: return data >> amt;
            MODE_SAR: return unsigned'(sdata >>> amt);
            default:  return (data << amt) | (data >> back);
        endcase
    endfunction

    assign k      = step_of(rem_r);
    assign accept = (state == ST_IDLE) && in_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            data_r <= '0;
            mode_r <= MODE_SHL;
            rem_r  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_r <= in_data;
                mode_r <= in_mode;
                rem_r  <= eff_amount(in_mode, in_amount);
            end else if (state == ST_SHIFT) begin
                data_r <= shift_step(data_r, mode_r, k);
                rem_r  <= rem_r - k;
            end
        end
    end

    // A zero-amount op still passes through SHIFT once, so the result never appears sooner than one cycle.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_r == k) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign out_data = data_r;

`ifdef SHIFT_UNIT_OVERFLOW_EN
    logic ovf_r;

    // The top k bits of the working value are the ones about to fall off the MSB end.
    function automatic logic lost_bits(input logic [WIDTH-1:0] data,
                                       input logic [REM_W-1:0] amt);
        logic [REM_W-1:0] back;
        back = REM_W'(WIDTH) - amt;
        return (data >> back) != '0;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (accept) begin
            ovf_r <= 1'b0;
        end else if ((state == ST_SHIFT) && (mode_r == MODE_SHL) && lost_bits(data_r, k)) begin
            ovf_r <= 1'b1;
        end
    end

    assign overflow = ovf_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: a STEP=1 and a STEP=4 instance checked against an arithmetic reference model.
module tb_shift_unit;

    localparam int W = 12;

    logic        clk;
    logic        reset;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [1:0]  in_mode   [2];
    logic [11:0] in_data   [2];
    logic [11:0] in_amount [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [11:0] out_data  [2];
    logic        overflow  [2];

    int checks = 0;
    int errors = 0;

    shift_unit #(.WIDTH(12), .AMT_WIDTH(12), .STEP(1)) u_s1 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
        .in_data(in_data[0]), .in_amount(in_amount[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .overflow(overflow[0])
    );

    shift_unit #(.WIDTH(12), .AMT_WIDTH(12), .STEP(4)) u_s4 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
        .in_data(in_data[1]), .in_amount(in_amount[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .overflow(overflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Reference: result, overflow and latency from plain arithmetic on the operands.
    function automatic void model(input int step, input logic [1:0] mode,
                                  input logic [11:0] data, input logic [11:0] amt,
                                  output logic [11:0] res, output logic ovf, output int lat);
        int     eff;
        longint full;
        int     v;
        logic [11:0] r;
        ovf = 1'b0;
        if (mode == 2'd3) eff = int'(amt) % W;
        else eff = (int'(amt) > W) ? W : int'(amt);
        case (mode)
            2'd0: begin
                full = longint'(data) << eff;
                res  = full[11:0];
`ifdef SHIFT_UNIT_OVERFLOW_EN
                ovf  = (full >> W) != 0;
`endif
            end
            2'd1: begin
                v   = int'(data) / (1 << eff);
                res = v[11:0];
            end
            2'd2: begin
                v   = (data >= 12'h800) ? int'(data) - 4096 : int'(data);
                v   = v >>> eff;
                res = v[11:0];
            end
            default: begin
                r = data;
                repeat (eff) r = {r[10:0], r[11]};
                res = r;
            end
        endcase
        lat = (eff + step - 1) / step;
        if (lat < 1) lat = 1;
    endfunction

    task automatic issue(input int d, input logic [1:0] m, input logic [11:0] dat,
                         input logic [11:0] amt);
        int guard;
        guard = 0;
        while (!in_ready[d] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready[d]) begin
            checks++; errors++;
            $display("FAIL issue_timeout dut%0d: in_ready=%0b required 1", d, in_ready[d]);
        end
        in_valid[d]  = 1'b1;
        in_mode[d]   = m;
        in_data[d]   = dat;
        in_amount[d] = amt;
        @(posedge clk); #1;
        in_valid[d]  = 1'b0;
        in_mode[d]   = 2'($urandom);
        in_data[d]   = 12'($urandom);
        in_amount[d] = 12'($urandom);
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[d] && lat < 100);
    endtask

    task automatic run_op(input int d, input logic [1:0] m, input logic [11:0] dat,
                          input logic [11:0] amt, input string name);
        logic [11:0] er;
        logic        eo;
        int          el;
        int          lat;
        model(step_of(d), m, dat, amt, er, eo, el);
        issue(d, m, dat, amt);
        wait_valid(d, lat);
        checks++;
        if (lat !== el) begin
            errors++;
            $display("FAIL %s_latency dut%0d: got %0d cycles, required %0d", name, d, lat, el);
        end
        checks++;
        if (out_data[d] !== er) begin
            errors++;
            $display("FAIL %s_data dut%0d m=%0d d=%h a=%0d: got %h, required %h",
                     name, d, m, dat, amt, out_data[d], er);
        end
        checks++;
        if (overflow[d] !== eo) begin
            errors++;
            $display("FAIL %s_overflow dut%0d: got %0b, required %0b", name, d, overflow[d], eo);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s_return_idle dut%0d: out_valid=%0b in_ready=%0b, required 0/1",
                     name, d, out_valid[d], in_ready[d]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0 || out_data[d] !== 12'h000 || overflow[d] !== 1'b0 ||
                in_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: valid=%0b data=%h ovf=%0b rdy=%0b, required 0/000/0/1",
                         d, out_valid[d], out_data[d], overflow[d], in_ready[d]);
            end
        end
    endtask

    task automatic test_directed();
        run_op(0, 2'd0, 12'h001, 12'd1,  "shl_1_by_1");
        run_op(0, 2'd0, 12'h801, 12'd4,  "shl_801_by_4");
        run_op(1, 2'd2, 12'h800, 12'd20, "sar_sat_step4");
        run_op(1, 2'd1, 12'h800, 12'd20, "shr_sat_step4");
        run_op(0, 2'd3, 12'h801, 12'd13, "rol_by_13");
        run_op(0, 2'd3, 12'h801, 12'd12, "rol_by_12");
        run_op(0, 2'd0, 12'hFFF, 12'd0,  "shl_by_0");
        run_op(0, 2'd2, 12'h7FF, 12'd4095, "sar_pos_max_amt");
        run_op(1, 2'd0, 12'h123, 12'd12, "shl_by_width_step4");
    endtask

    task automatic test_random();
        logic [11:0] amt;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                amt = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 14));
                run_op(d, 2'($urandom), 12'($urandom), amt, "random");
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] er;
        logic        eo;
        int          el;
        int          lat;
        bit          bad;
        model(1, 2'd1, 12'hA5C, 12'd3, er, eo, el);
        out_ready[0] = 1'b0;
        issue(0, 2'd1, 12'hA5C, 12'd3);
        wait_valid(0, lat);
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== er) begin
            errors++;
            $display("FAIL hold_first dut0: valid=%0b data=%h, required 1/%h", out_valid[0], out_data[0], er);
        end
        in_valid[0]  = 1'b1;
        in_mode[0]   = 2'd0;
        in_data[0]   = 12'h001;
        in_amount[0] = 12'd1;
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b1 || out_data[0] !== er || in_ready[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_stable dut0: valid=%0b data=%h rdy=%0b, required 1/%h/0",
                     out_valid[0], out_data[0], in_ready[0], er);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release dut0: rdy=%0b valid=%0b, required 1/0", in_ready[0], out_valid[0]);
        end
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_offer_not_taken dut0: valid=%0b rdy=%0b, required 0/1", out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_reset_midop();
        bit seen;
        issue(0, 2'd0, 12'h0FF, 12'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_data[0] !== 12'h000 ||
            overflow[0] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset dut0: valid=%0b rdy=%0b data=%h ovf=%0b, required 0/1/000/0",
                     out_valid[0], in_ready[0], out_data[0], overflow[0]);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midop_discard dut0: out_valid=1 seen, required 0 throughout");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(1, 2'(i % 4), 12'($urandom), 12'($urandom_range(0, 24)), "b2b");
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_mode[d]   = 2'd0;
            in_data[d]   = 12'h000;
            in_amount[d] = 12'h000;
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
